// File: rtl/bicubic_pkg.sv
// Shared definitions for the bicubic scaler coordinate generators.
package bicubic_pkg;

  // Default datapath widths.
  localparam int ROW_W  = 11;   // row index width, up to 2047 lines
  localparam int STEP_W = 20;   // Q4.16 scale step
  localparam int ACC_W  = 28;   // signed Q11.16 accumulator

  // Blend weights in Q8 (256 = 1.0).
  localparam logic [8:0] COEFF_ONE  = 9'd256;
  localparam logic [8:0] COEFF_HALF = 9'd128;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/bicubic_y_coord_gen_if.sv
// Coordinate stream from the vertical coordinate generator to its consumers.
interface bicubic_y_coord_gen_if #(
  parameter int ROW_W = 11
);
  logic                 coord_valid;
  logic                 coord_ready;
  logic [ROW_W-1:0]     coord_dst_row;
  logic [ROW_W-1:0]     coord_row;
  logic [4*ROW_W-1:0]   coord_taps;
  logic [8:0]           coord_yBlend;
  logic [1:0]           coord_adv;
  logic                 coord_last;

  modport master (
    output coord_valid, coord_dst_row, coord_row, coord_taps,
           coord_yBlend, coord_adv, coord_last,
    input  coord_ready
  );

  modport slave (
    input  coord_valid, coord_dst_row, coord_row, coord_taps,
           coord_yBlend, coord_adv, coord_last,
    output coord_ready
  );
endinterface

// File: rtl/bicubic_row_clamp.sv
// Expands a centre row into the four bicubic taps {y3,y2,y1,y0} = row-1..row+2,
// each clamped into [0, src_h-1]. A zero source height behaves like one line.
module bicubic_row_clamp #(
  parameter int ROW_W = 11
) (
  input  logic [ROW_W-1:0]   row,
  input  logic [ROW_W-1:0]   src_h,
  output logic [4*ROW_W-1:0] taps
);

  logic [ROW_W-1:0] max_row;

  assign max_row = (src_h == '0) ? '0 : src_h - ROW_W'(1);

  // ofs is the tap row plus one, so row-1 never underflows in the wide domain.
  for (genvar gi = 0; gi < 4; gi++) begin : g_tap
    logic [ROW_W+1:0] ofs;
    logic [ROW_W+1:0] y_ext;
    assign ofs   = {2'b00, row} + (ROW_W+2)'(gi);
    assign y_ext = (ofs == '0) ? '0 : ofs - (ROW_W+2)'(1);
    assign taps[gi*ROW_W +: ROW_W] = (y_ext > {2'b00, max_row}) ? max_row
                                                                 : y_ext[ROW_W-1:0];
  end

endmodule

// File: rtl/bicubic_y_coord_gen.sv
// Vertical source-coordinate generator: steps a Q11.16 accumulator per output
// line and presents centre row, clamped taps, Q8 blend and line advance.
module bicubic_y_coord_gen #(
  parameter int ROW_W  = bicubic_pkg::ROW_W,
  parameter int STEP_W = bicubic_pkg::STEP_W,
  parameter int ACC_W  = bicubic_pkg::ACC_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [STEP_W-1:0]     cfg_step,
  input  logic [ROW_W-1:0]      cfg_src_h,
  input  logic [ROW_W-1:0]      cfg_dst_h,
  input  logic                  frame_start,
  bicubic_y_coord_gen_if.master coord,
  output logic                  frame_done,
  output logic                  busy
);
  import bicubic_pkg::*;

  localparam int FRAC     = 16;
  localparam int ACC_HALF = 32'h8000;

  fsm_state_t         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [ROW_W-1:0]   src_h_q, src_h_d;
  logic [ROW_W-1:0]   dst_h_q, dst_h_d;
  logic [ROW_W-1:0]   dst_row_q, dst_row_d;
  logic [ROW_W-1:0]   prev_row_q, prev_row_d;
  logic               out_load;
  logic               first_line;

  logic [ROW_W-1:0]   row_q, row_c;
  logic [8:0]         yblend_q, yblend_c;
  logic [4*ROW_W-1:0] taps_q, taps_c;
  logic [1:0]         adv_q, adv_c;
  logic               last_q, last_c;

  logic [ROW_W+7:0]   r_c;
  logic [ROW_W-1:0]   row_raw, max_row_c, diff_c;
  logic [8:0]         yblend_raw;

  // Next-state, accumulator stepping and config capture.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    step_d     = step_q;
    src_h_d    = src_h_q;
    dst_h_d    = dst_h_q;
    dst_row_d  = dst_row_q;
    prev_row_d = prev_row_q;
    out_load   = 1'b0;
    first_line = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          step_d  = cfg_step;
          src_h_d = cfg_src_h;
          dst_h_d = cfg_dst_h;
          state_d = (cfg_dst_h == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Centre alignment: first sample sits at 0.5*step - 0.5.
        acc_d      = {{(ACC_W-STEP_W+1){1'b0}}, step_q[STEP_W-1:1]} - ACC_W'(ACC_HALF);
        dst_row_d  = '0;
        prev_row_d = '0;
        out_load   = 1'b1;
        first_line = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (coord.coord_ready) begin
          if (last_q) begin
            state_d = ST_DONE;
          end else begin
            acc_d      = acc_q + {{(ACC_W-STEP_W){1'b0}}, step_q};
            dst_row_d  = dst_row_q + ROW_W'(1);
            prev_row_d = row_q;
            out_load   = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Coordinate of the accumulator value about to be registered.
  always_comb begin
    r_c        = acc_d[FRAC+ROW_W-1:8] + {{(ROW_W+7){1'b0}}, acc_d[7]};
    row_raw    = r_c[ROW_W+7:8];
    yblend_raw = {1'b0, r_c[7:0]};
    // A rounding carry out of the fraction keeps the row and reports a full blend.
    if ((&acc_d[15:8]) && acc_d[7]) begin
      row_raw    = acc_d[FRAC+ROW_W-1:FRAC];
      yblend_raw = COEFF_ONE;
    end
    if (acc_d[ACC_W-1]) begin
      row_raw    = '0;
      yblend_raw = '0;
    end
    max_row_c = (src_h_q == '0) ? '0 : src_h_q - ROW_W'(1);
    if (row_raw >= max_row_c) begin
      row_c    = max_row_c;
      yblend_c = '0;
    end else begin
      row_c    = row_raw;
      yblend_c = yblend_raw;
    end
    diff_c = row_c - prev_row_d;
    if (first_line)
      adv_c = 2'd0;
    else
      adv_c = (diff_c > ROW_W'(3)) ? 2'd3 : diff_c[1:0];
    last_c = (dst_row_d == dst_h_q - ROW_W'(1));
  end

  bicubic_row_clamp #(.ROW_W(ROW_W)) u_clamp (
    .row   (row_c),
    .src_h (src_h_q),
    .taps  (taps_c)
  );

  // Control and accumulator state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      step_q     <= '0;
      src_h_q    <= '0;
      dst_h_q    <= '0;
      dst_row_q  <= '0;
      prev_row_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      src_h_q    <= src_h_d;
      dst_h_q    <= dst_h_d;
      dst_row_q  <= dst_row_d;
      prev_row_q <= prev_row_d;
    end
  end

  // Output registers, refreshed only when a new coordinate is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q    <= '0;
      yblend_q <= '0;
      taps_q   <= '0;
      adv_q    <= '0;
      last_q   <= 1'b0;
    end else if (out_load) begin
      row_q    <= row_c;
      yblend_q <= yblend_c;
      taps_q   <= taps_c;
      adv_q    <= adv_c;
      last_q   <= last_c;
    end
  end

  assign coord.coord_valid   = (state_q == ST_RUN);
  assign coord.coord_dst_row = dst_row_q;
  assign coord.coord_row     = row_q;
  assign coord.coord_taps    = taps_q;
  assign coord.coord_yBlend  = yblend_q;
  assign coord.coord_adv     = adv_q;
  assign coord.coord_last    = last_q;
  assign frame_done          = (state_q == ST_DONE);
  assign busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bicubic_y_coord_gen.sv
// Directed bench for the vertical coordinate generator.
module tb_bicubic_y_coord_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] cfg_step;
  logic [10:0] cfg_src_h;
  logic [10:0] cfg_dst_h;
  logic        frame_start;
  logic        frame_done;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_row[8];
  int exp_yb[8];
  int exp_adv[8];

  bicubic_y_coord_gen_if #(.ROW_W(11)) cif ();

  bicubic_y_coord_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_step    (cfg_step),
    .cfg_src_h   (cfg_src_h),
    .cfg_dst_h   (cfg_dst_h),
    .frame_start (frame_start),
    .coord       (cif.master),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference taps {y3,y2,y1,y0}: row-1..row+2 clamped to [0, src-1].
  function automatic logic [43:0] taps_model(input int row, input int src);
    logic [43:0] t;
    int mx;
    int y;
    mx = (src == 0) ? 0 : src - 1;
    t = '0;
    for (int k = 0; k < 4; k++) begin
      y = row - 1 + k;
      if (y < 0) y = 0;
      if (y > mx) y = mx;
      t[k*11 +: 11] = 11'(y);
    end
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_coord(input string name, input int i, input int n, input int src);
    check($sformatf("%s valid[%0d]", name, i), 64'(cif.coord_valid), 64'd1);
    check($sformatf("%s dst_row[%0d]", name, i), 64'(cif.coord_dst_row), 64'(i));
    check($sformatf("%s row[%0d]", name, i), 64'(cif.coord_row), 64'(exp_row[i]));
    check($sformatf("%s yblend[%0d]", name, i), 64'(cif.coord_yBlend), 64'(exp_yb[i]));
    check($sformatf("%s adv[%0d]", name, i), 64'(cif.coord_adv), 64'(exp_adv[i]));
    check($sformatf("%s last[%0d]", name, i), 64'(cif.coord_last), 64'(i == n - 1));
    check($sformatf("%s taps[%0d]", name, i), 64'(cif.coord_taps), 64'(taps_model(exp_row[i], src)));
    check($sformatf("%s done_mid[%0d]", name, i), 64'(frame_done), 64'd0);
  endtask

  // Runs one frame against exp_* tables; optional stall and stray frame_start.
  task automatic run_frame(input string name, input logic [19:0] step, input int src, input int n,
                           input int stall_at, input int stall_len, input int pulse_at);
    cfg_step    = step;
    cfg_src_h   = 11'(src);
    cfg_dst_h   = 11'(n);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cfg_step    = 20'hABCDE;
    cfg_src_h   = 11'd7;
    cfg_dst_h   = 11'd1;
    check({name, " load_valid"}, 64'(cif.coord_valid), 64'd0);
    check({name, " load_busy"}, 64'(busy), 64'd1);
    tick();
    for (int i = 0; i < n; i++) begin
      check_coord(name, i, n, src);
      if (i == stall_at) begin
        cif.coord_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check_coord({name, " stall"}, i, n, src);
        end
        cif.coord_ready = 1'b1;
      end
      if (i == pulse_at) begin
        cfg_dst_h   = 11'd5;
        frame_start = 1'b1;
      end
      tick();
      frame_start = 1'b0;
    end
    check({name, " done"}, 64'(frame_done), 64'd1);
    check({name, " done_valid"}, 64'(cif.coord_valid), 64'd0);
    tick();
    check({name, " done_pulse"}, 64'(frame_done), 64'd0);
    check({name, " idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    frame_start     = 1'b0;
    cfg_step        = '0;
    cfg_src_h       = '0;
    cfg_dst_h       = '0;
    cif.coord_ready = 1'b1;
    #3;
    check("rst valid", 64'(cif.coord_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(frame_done), 64'd0);
    check("rst row", 64'(cif.coord_row), 64'd0);
    check("rst taps", 64'(cif.coord_taps), 64'd0);
    check("rst yblend", 64'(cif.coord_yBlend), 64'd0);
    check("rst dst_row", 64'(cif.coord_dst_row), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // 1:1 scale: rows 0..3, no blend.
    exp_row = '{0, 1, 2, 3, 0, 0, 0, 0};
    exp_yb  = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_adv = '{0, 1, 1, 1, 0, 0, 0, 0};
    check("unity taps0 model", 64'(taps_model(0, 4)), 64'({11'd2, 11'd1, 11'd0, 11'd0}));
    run_frame("unity", 20'h10000, 4, 4, -1, 0, -1);

    // 2x upscale: last line clamps to src_h-1 with blend forced to 0.
    exp_row = '{0, 0, 0, 1, 0, 0, 0, 0};
    exp_yb  = '{0, 64, 192, 0, 0, 0, 0, 0};
    exp_adv = '{0, 0, 0, 1, 0, 0, 0, 0};
    run_frame("up2x", 20'h08000, 2, 4, -1, 0, -1);

    // 3:4 scale with and without a 5-cycle stall.
    exp_row = '{0, 0, 1, 2, 0, 0, 0, 0};
    exp_yb  = '{0, 160, 96, 0, 0, 0, 0, 0};
    exp_adv = '{0, 0, 1, 1, 0, 0, 0, 0};
    run_frame("s34", 20'h0C000, 3, 4, -1, 0, -1);
    run_frame("s34bp", 20'h0C000, 3, 4, 1, 5, -1);

    // Rounding carry: acc frac 0xFFA0 gives blend 256 on row 0.
    exp_row = '{0, 0, 1, 2, 3, 4, 5, 6};
    exp_yb  = '{0, 256, 255, 255, 255, 255, 254, 254};
    exp_adv = '{0, 0, 1, 1, 1, 1, 1, 1};
    run_frame("carry", 20'h0FFC0, 16, 8, -1, 0, -1);

    // 4x downscale: first line adv 0, then saturation at 3.
    exp_row = '{1, 5, 9, 13, 0, 0, 0, 0};
    exp_yb  = '{128, 128, 128, 128, 0, 0, 0, 0};
    exp_adv = '{0, 3, 3, 3, 0, 0, 0, 0};
    run_frame("down4x", 20'h40000, 16, 4, -1, 0, -1);

    // Zero destination height: immediate frame_done, no coordinates.
    cfg_step    = 20'h10000;
    cfg_src_h   = 11'd4;
    cfg_dst_h   = 11'd0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("dst0 done", 64'(frame_done), 64'd1);
    check("dst0 valid", 64'(cif.coord_valid), 64'd0);
    tick();
    check("dst0 done_pulse", 64'(frame_done), 64'd0);
    check("dst0 valid2", 64'(cif.coord_valid), 64'd0);
    check("dst0 busy", 64'(busy), 64'd0);

    // Stray frame_start during RUN is ignored: exactly 3 lines.
    exp_row = '{0, 1, 2, 0, 0, 0, 0, 0};
    exp_yb  = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_adv = '{0, 1, 1, 0, 0, 0, 0, 0};
    run_frame("ignore", 20'h10000, 4, 3, -1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("ignore post_valid[%0d]", k), 64'(cif.coord_valid), 64'd0);
    end

    // Reset mid-frame clears outputs asynchronously, then a clean restart.
    cfg_step    = 20'h10000;
    cfg_src_h   = 11'd4;
    cfg_dst_h   = 11'd4;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    check("mid row_before", 64'(cif.coord_row), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("mid rst valid", 64'(cif.coord_valid), 64'd0);
    check("mid rst busy", 64'(busy), 64'd0);
    check("mid rst row", 64'(cif.coord_row), 64'd0);
    check("mid rst dst_row", 64'(cif.coord_dst_row), 64'd0);
    check("mid rst taps", 64'(cif.coord_taps), 64'd0);
    check("mid rst adv", 64'(cif.coord_adv), 64'd0);
    tick();
    tick();
    check("mid rst no_done", 64'(frame_done), 64'd0);
    rst_n = 1'b1;
    tick();
    exp_row = '{0, 1, 2, 3, 0, 0, 0, 0};
    exp_yb  = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_adv = '{0, 1, 1, 1, 0, 0, 0, 0};
    run_frame("restart", 20'h10000, 4, 4, -1, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
